// File: rtl/matrix_cell_streamer_pkg.sv
// Shared definitions for the flattened-matrix producer/consumer pair.
package matrix_cell_streamer_pkg;

  localparam int unsigned ROWS_DEF = 2;
  localparam int unsigned COLS_DEF = 3;
  localparam int unsigned W_DEF    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bit offset of cell (r,c) inside a row-major packed matrix.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned cols, input int unsigned w);
    return (r * cols + c) * w;
  endfunction

endpackage

// File: rtl/matrix_cell_streamer_rc_counter.sv
// Row/column wrap counter walking a ROWS x COLS grid in row-major order.
module matrix_cell_streamer_rc_counter #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [7:0] row_o,
  output logic [7:0] col_o,
  output logic       last_o
);

  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;

  // Clear wins over advance; column wraps into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == 8'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == 8'(ROWS - 1)) ? '0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Index registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == 8'(ROWS - 1)) && (col_q == 8'(COLS - 1));

endmodule

// File: rtl/matrix_cell_streamer.sv
// Accepts one packed matrix, streams its cells row-major with indices,
// and reports the cell sum with a one-cycle done pulse.
module matrix_cell_streamer
  import matrix_cell_streamer_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned W    = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*COLS*W-1:0] in_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_row,
  output logic [7:0]             out_col,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic                   done,
  output logic [W+7:0]           sum
);

  localparam int unsigned FW = ROWS * COLS * W;

  state_e          state_q, state_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [W+7:0]    acc_q, acc_d;
  logic [W+7:0]    sum_q, sum_d;
  logic            done_q, done_d;
  logic            cnt_clear, cnt_adv;
  logic [7:0]      row, col;
  logic            is_last;
  logic [FW-1:0]   shifted;

  matrix_cell_streamer_rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rc_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (cnt_clear),
    .advance_i (cnt_adv),
    .row_o     (row),
    .col_o     (col),
    .last_o    (is_last)
  );

  // Cell select by shifting the shadow copy; avoids an oversized part-select index.
  always_comb begin
    shifted  = shadow_q >> idx(32'(row), 32'(col), COLS, W);
    out_data = shifted[W-1:0];
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = (state_q == SEND) && is_last;
  assign done      = done_q;
  assign sum       = sum_q;

  // Next-state: accept in IDLE, walk cells and accumulate in SEND.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          shadow_d  = in_flat;
          acc_d     = '0;
          cnt_clear = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          acc_d = acc_q + (W + 8)'(out_data);
          if (is_last) begin
            sum_d   = acc_q + (W + 8)'(out_data);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/matrix_cell_streamer.md
Name: matrix_cell_streamer

Overview:
- Consumer for the flattened-matrix format produced by the matrix-scaling block, whose output is a ROWS x COLS matrix of W-bit cells packed row-major into one vector.
- Accepts one flat matrix per valid/ready handshake and emits its cells one at a time in row-major order, tagged with row/col indices, under valid/ready backpressure.
- Keeps a running sum of the emitted cells and reports it with a one-cycle done pulse after each matrix.
- Sits between the matrix producer and any per-cell downstream logic.

Parameters:
- ROWS, 2, number of matrix rows (1..255).
- COLS, 3, number of matrix columns (1..255).
- W, 8, bits per cell.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_flat holds a matrix to accept.
- in_ready  output  1  streamer can accept a matrix.
- in_flat  input  ROWS*COLS*W  packed matrix; cell (r,c) = in_flat[(r*COLS+c)*W +: W].
- out_valid  output  1  out_row/out_col/out_data/out_last are valid.
- out_ready  input  1  downstream accepts the current cell.
- out_row  output  8  row index of the current cell.
- out_col  output  8  column index of the current cell.
- out_data  output  W  value of the current cell.
- out_last  output  1  current cell is (ROWS-1, COLS-1).
- done  output  1  one-cycle pulse after the last cell handshake.
- sum  output  W+8  sum of all cells of the last completed matrix.

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-low; one clock; no other resets.
  - While rst_n=0 at a posedge: state<=IDLE; row, col, shadow, acc, sum, done all <=0.
  - in_ready is gated by rst_n, so it is 0 while rst_n=0.
  - out_valid is 0 during and after reset until the next accept.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&in_ready, capture shadow<=in_flat, row<=0, col<=0, acc<=0, go to SEND.
  - SEND: in_ready=0, out_valid=1.
    - out_data = shadow[(row*COLS+col)*W +: W]; out_row=row; out_col=col; out_last=(row==ROWS-1 && col==COLS-1).
    - On out_valid&out_ready: acc<=acc+out_data, zero-extended to W+8.
    - Not last: col<=col+1; if col==COLS-1 then col<=0, row<=row+1.
    - Last: sum<=acc+out_data; done<=1 next cycle; state<=IDLE.
- Latency and throughput:
  - First cell is visible the cycle after the accept handshake.
  - With out_ready held at 1, a matrix takes exactly ROWS*COLS+1 cycles from accept to re-entering IDLE.
  - in_ready returns the cycle after the last handshake.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_* are held stable and row/col/acc do not change.
  - in_flat changes during SEND have no effect, since the shadow copy is used.
- done is 1 for exactly one cycle and never asserts in IDLE otherwise.
- sum holds its value until the next matrix completes; acc is internal only.
- Sum width W+8 cannot overflow for ROWS*COLS <= 256; larger sizes wrap mod 2^(W+8).
- Reset mid-SEND: matrix discarded, no done, sum<=0, back to IDLE.

Decomposition:
- Shared package:
  - Default ROWS/COLS/W constants.
  - Cell bit-offset function idx(r,c) = (r*COLS+c)*W, used by this block and the producer.
  - State enum {IDLE, SEND}.
- One natural sub-module: rc_counter, a row/col wrap counter with advance, clear and is_last outputs.

Test Plan:
- Basic stream: in_flat=48'h060504030201, out_ready=1 -> cells (0,0)=01, (0,1)=02, (0,2)=03, (1,0)=04, (1,1)=05, (1,2)=06 on consecutive cycles starting 1 cycle after accept; out_last only on (1,2); done pulse next cycle; sum=16'h0015.
- Backpressure: same input, out_ready low for 3 cycles while (0,1) is presented -> (0,1)=02 held stable for all 3 cycles; no skipped or duplicated cell; sum=16'h0015.
- Saturation: in_flat all 8'hFF -> six cells of FF; sum=16'h05FA; no wrap.
- Back-to-back: second matrix 48'h0A0A0A0A0A0A presented while busy -> in_ready=0 until the cycle after the first out_last handshake; then accepted; sum=16'h003C after the second done.
- Reset mid-operation: rst_n=0 one cycle after (0,2) is presented -> next cycle out_valid=0, in_ready=1 after rst_n=1, sum=0, no done pulse.
- Reset values: hold rst_n=0 for 2 cycles -> in_ready=0, out_valid=0, done=0, sum=0 throughout.
